// File: rtl/motor_drive_seq.sv
// H-bridge drive sequencer: ramps the duty toward a selected speed, gates the PWM
// enables, and runs a stop / dead-time sequence before every reversal or stop.
//
// state | meaning
// IDLE  | motors off, duty held at 0, direction pins low
// DRIVE | direction pins driven, duty ramps toward the speed_sel target
// STOP  | direction pins still driven, duty ramps down to 0
// DEAD  | direction pins low for DEADTIME cycles (also the estop hold state)
module motor_drive_seq #(
   parameter int RAMP_DIV  = 390625,
   parameter int RAMP_STEP = 8,
   parameter int DEADTIME  = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_req,
   input  logic       dir_req,
   input  logic [2:0] speed_sel,
   input  logic       estop,
   output logic       en_a,
   output logic       en_b,
   output logic       in1,
   output logic       in2,
   output logic [7:0] duty,
   output logic [1:0] state_o,
   output logic       busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_STOP  = 2'd2;
   localparam logic [1:0] S_DEAD  = 2'd3;

   localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
   localparam logic [PW-1:0] PRE_TC  = PW'(RAMP_DIV - 1);
   localparam logic [DW-1:0] DEAD_LD = DW'(DEADTIME - 1);
   localparam logic [8:0]    STEP9   = 9'(RAMP_STEP);
   localparam logic [7:0]    STEP8   = 8'(RAMP_STEP);
   localparam logic [7:0]    PWM_TC  = 8'd254;

   logic [1:0]    state;
   logic          dir_lat;
   logic [7:0]    duty_r;
   logic [PW-1:0] pre_cnt;
   logic [DW-1:0] dead_cnt;
   logic [7:0]    pwm_cnt;
   logic [7:0]    shadow;
   logic          en_r;

   logic          tick;
   logic [7:0]    sel_duty;
   logic [7:0]    target;
   logic [8:0]    sum9;
   logic [8:0]    lim9;
   logic [7:0]    duty_ramp;
   logic [7:0]    shadow_nxt;
   logic          drv;

   // Free-running ramp prescaler, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_TC) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   assign tick = (pre_cnt == PRE_TC);

   always_comb begin
      sel_duty = 8'd0;
      case (speed_sel)
         3'd0:    sel_duty = 8'd0;
         3'd1:    sel_duty = 8'd40;
         3'd2:    sel_duty = 8'd80;
         3'd3:    sel_duty = 8'd120;
         3'd4:    sel_duty = 8'd160;
         3'd5:    sel_duty = 8'd200;
         3'd6:    sel_duty = 8'd240;
         default: sel_duty = 8'd255;
      endcase
   end

   assign target = (state == S_DRIVE) ? sel_duty : 8'd0;

   // One ramp step toward target, clamped so it never crosses the target
   always_comb begin
      sum9      = {1'b0, duty_r} + STEP9;
      lim9      = {1'b0, target} + STEP9;
      duty_ramp = duty_r;
      if (duty_r < target) begin
         duty_ramp = (sum9 > {1'b0, target}) ? target : sum9[7:0];
      end else if (duty_r > target) begin
         duty_ramp = ({1'b0, duty_r} < lim9) ? target : (duty_r - STEP8);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         dir_lat  <= 1'b0;
         duty_r   <= 8'd0;
         dead_cnt <= '0;
      end else if (estop) begin
         state    <= S_DEAD;
         dead_cnt <= DEAD_LD;
         duty_r   <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               duty_r <= 8'd0;
               if (run_req) begin
                  dir_lat <= dir_req;
                  state   <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (tick) begin
                  duty_r <= duty_ramp;
               end
               if (!run_req || (dir_req != dir_lat)) begin
                  state <= S_STOP;
               end
            end
            S_STOP: begin
               if (duty_r == 8'd0) begin
                  state    <= S_DEAD;
                  dead_cnt <= DEAD_LD;
               end else if (tick) begin
                  duty_r <= duty_ramp;
               end
            end
            default: begin
               if (dead_cnt == '0) begin
                  if (run_req) begin
                     dir_lat <= dir_req;
                     state   <= S_DRIVE;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  dead_cnt <= dead_cnt - DW'(1);
               end
            end
         endcase
      end
   end

   // The compare uses the value the shadow takes this cycle, so each 255-cycle
   // period holds exactly `shadow` high cycles.
   assign shadow_nxt = estop ? 8'd0 : ((pwm_cnt == 8'd0) ? duty_r : shadow);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= 8'd0;
         shadow  <= 8'd0;
         en_r    <= 1'b0;
      end else begin
         pwm_cnt <= (pwm_cnt == PWM_TC) ? 8'd0 : (pwm_cnt + 8'd1);
         shadow  <= shadow_nxt;
         en_r    <= (pwm_cnt < shadow_nxt);
      end
   end

   assign drv     = (state == S_DRIVE) || (state == S_STOP);
   assign en_a    = en_r & drv;
   assign en_b    = en_r & drv;
   assign in1     = drv & ~dir_lat;
   assign in2     = drv & dir_lat;
   assign duty    = duty_r;
   assign state_o = state;
   assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_motor_drive_seq.sv
// Scoreboard bench for motor_drive_seq: stimulus pushes expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_motor_drive_seq;

   localparam int SIG_STATE = 0;
   localparam int SIG_DUTY  = 1;
   localparam int SIG_IN1   = 2;
   localparam int SIG_IN2   = 3;
   localparam int SIG_EN    = 4;
   localparam int SIG_BUSY  = 5;
   localparam int SIG_ENWIN = 6;

   typedef struct {
      string name;
      int    sig;
      int    exp;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       run_req;
   logic       dir_req;
   logic [2:0] speed_sel;
   logic       estop;
   logic       en_a;
   logic       en_b;
   logic       in1;
   logic       in2;
   logic [7:0] duty;
   logic [1:0] state_o;
   logic       busy;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   en_win = 0;

   motor_drive_seq #(
      .RAMP_DIV (4),
      .RAMP_STEP(8),
      .DEADTIME (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run_req  (run_req),
      .dir_req  (dir_req),
      .speed_sel(speed_sel),
      .estop    (estop),
      .en_a     (en_a),
      .en_b     (en_b),
      .in1      (in1),
      .in2      (in2),
      .duty     (duty),
      .state_o  (state_o),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int get_act(int sig);
      case (sig)
         SIG_STATE: return int'(state_o);
         SIG_DUTY:  return int'(duty);
         SIG_IN1:   return int'(in1);
         SIG_IN2:   return int'(in2);
         SIG_EN:    return int'(en_a);
         SIG_BUSY:  return int'(busy);
         default:   return en_win;
      endcase
   endfunction

   task automatic push(string nm, int sig, int v);
      exp_t e;
      e.name = nm;
      e.sig  = sig;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic tick_n(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_sig(string nm, int sig, int v, int bound);
      for (int i = 0; i < bound; i++) begin
         @(posedge clk);
         #1;
         if (get_act(sig) == v) return;
      end
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, value %0d, wanted %0d", nm, bound, get_act(sig), v);
   endtask

   task automatic measure_en(string nm, int v);
      tick_n(256);
      en_win = 0;
      repeat (255) begin
         @(negedge clk);
         en_win += int'(en_a);
      end
      push(nm, SIG_ENWIN, v);
      tick_n(1);
   endtask

   // Monitor: invariants every cycle plus all queued expectations
   always @(negedge clk) begin
      exp_t e;
      int   a;
      if (rst_n) begin
         checks++;
         if ((en_a !== en_b) || (in1 && in2) || (busy !== (state_o != 2'd0))) begin
            errors++;
            $display("FAIL invariant: en_a=%0b en_b=%0b in1=%0b in2=%0b busy=%0b state=%0d",
                     en_a, en_b, in1, in2, busy, state_o);
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         a = get_act(e.sig);
         checks++;
         if (a != e.exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, a, e.exp, $time);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      run_req   = 1'b1;
      dir_req   = 1'b1;
      speed_sel = 3'd7;
      estop     = 1'b0;

      // Reset
      tick_n(3);
      push("rst_state", SIG_STATE, 0);
      push("rst_duty", SIG_DUTY, 0);
      push("rst_in1", SIG_IN1, 0);
      push("rst_in2", SIG_IN2, 0);
      push("rst_en", SIG_EN, 0);
      push("rst_busy", SIG_BUSY, 0);
      run_req = 1'b0;
      tick_n(1);
      rst_n = 1'b1;
      tick_n(6);
      push("post_rst_state", SIG_STATE, 0);
      push("post_rst_duty", SIG_DUTY, 0);
      push("post_rst_in1", SIG_IN1, 0);

      // Ramp up to 120
      run_req   = 1'b1;
      dir_req   = 1'b0;
      speed_sel = 3'd3;
      tick_n(1);
      push("up_state", SIG_STATE, 1);
      push("up_in1", SIG_IN1, 1);
      push("up_in2", SIG_IN2, 0);
      push("up_duty0", SIG_DUTY, 0);
      wait_sig("up_first", SIG_DUTY, 8, 6);
      push("up_step1", SIG_DUTY, 8);
      for (int k = 2; k <= 15; k++) begin
         tick_n(4);
         push("up_step", SIG_DUTY, 8 * k);
      end
      tick_n(8);
      push("up_hold", SIG_DUTY, 120);
      measure_en("en_win_120", 120);

      // Speed change down to 40
      speed_sel = 3'd1;
      wait_sig("dn_first", SIG_DUTY, 112, 6);
      push("dn_step1", SIG_DUTY, 112);
      for (int k = 2; k <= 10; k++) begin
         tick_n(4);
         push("dn_step", SIG_DUTY, 120 - 8 * k);
      end
      tick_n(8);
      push("dn_hold", SIG_DUTY, 40);
      push("dn_state", SIG_STATE, 1);

      // Back to 120, then reverse
      speed_sel = 3'd3;
      wait_sig("re_up", SIG_DUTY, 120, 60);
      dir_req = 1'b1;
      tick_n(1);
      push("rev_stop", SIG_STATE, 2);
      push("rev_stop_in1", SIG_IN1, 1);
      push("rev_stop_in2", SIG_IN2, 0);
      wait_sig("rev_dead", SIG_STATE, 3, 80);
      push("rev_dead_duty", SIG_DUTY, 0);
      push("rev_dead_in1", SIG_IN1, 0);
      push("rev_dead_in2", SIG_IN2, 0);
      push("rev_dead_en", SIG_EN, 0);
      push("rev_dead_busy", SIG_BUSY, 1);
      tick_n(15);
      push("rev_dead_15", SIG_STATE, 3);
      push("rev_dead_15_in2", SIG_IN2, 0);
      tick_n(1);
      push("rev_drive", SIG_STATE, 1);
      push("rev_in1", SIG_IN1, 0);
      push("rev_in2", SIG_IN2, 1);
      wait_sig("rev_ramp", SIG_DUTY, 120, 80);
      push("rev_ramp_state", SIG_STATE, 1);

      // estop at duty 200, run_req kept high
      speed_sel = 3'd5;
      wait_sig("to_200", SIG_DUTY, 200, 60);
      estop = 1'b1;
      tick_n(1);
      push("es_duty", SIG_DUTY, 0);
      push("es_state", SIG_STATE, 3);
      push("es_en", SIG_EN, 0);
      push("es_in1", SIG_IN1, 0);
      push("es_in2", SIG_IN2, 0);
      tick_n(49);
      push("es_hold_state", SIG_STATE, 3);
      push("es_hold_duty", SIG_DUTY, 0);
      estop = 1'b0;
      tick_n(15);
      push("es_rel_15", SIG_STATE, 3);
      tick_n(1);
      push("es_rel_drive", SIG_STATE, 1);
      push("es_rel_in2", SIG_IN2, 1);

      // estop with run_req dropped during the hold
      estop = 1'b1;
      tick_n(5);
      run_req = 1'b0;
      tick_n(2);
      estop = 1'b0;
      tick_n(15);
      push("es2_rel_15", SIG_STATE, 3);
      tick_n(1);
      push("es2_idle", SIG_STATE, 0);
      push("es2_busy", SIG_BUSY, 0);

      // Extremes: full duty then zero duty
      run_req   = 1'b1;
      dir_req   = 1'b0;
      speed_sel = 3'd7;
      tick_n(1);
      push("ext_state", SIG_STATE, 1);
      push("ext_in1", SIG_IN1, 1);
      wait_sig("ext_255", SIG_DUTY, 255, 140);
      tick_n(8);
      push("ext_hold_255", SIG_DUTY, 255);
      measure_en("en_win_255", 255);
      speed_sel = 3'd0;
      wait_sig("ext_0", SIG_DUTY, 0, 140);
      push("ext0_state", SIG_STATE, 1);
      push("ext0_in1", SIG_IN1, 1);
      push("ext0_in2", SIG_IN2, 0);
      measure_en("en_win_0", 0);

      // Asynchronous reset mid-operation
      speed_sel = 3'd3;
      wait_sig("pre_rst", SIG_DUTY, 120, 80);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      push("arst_state", SIG_STATE, 0);
      push("arst_duty", SIG_DUTY, 0);
      push("arst_in1", SIG_IN1, 0);
      push("arst_en", SIG_EN, 0);
      push("arst_busy", SIG_BUSY, 0);
      tick_n(3);

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/motor_drive_seq.md
# motor_drive_seq

Sequencer between the operator switch/debounce logic and the H-bridge PMOD pins for the two drive motors. It turns a run request, a direction request and a 3-bit speed select into a ramped 8-bit duty and gated PWM enables. It also drives the H-bridge direction pins with an enforced stop, coast and dead-time sequence on every reversal or stop. All request inputs arrive already synchronous to `clk` from the upstream debouncer.

## Interface
- `RAMP_DIV`, default 390625: clock cycles per ramp tick; must be ≥1.
- `RAMP_STEP`, default 8: duty change per ramp tick, 1..255.
- `DEADTIME`, default 1000000: cycles spent in DEAD with both direction pins low; must be ≥1.
- `clk`  in  1  system clock; the only clock for this block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `run_req`  in  1  1 = motors should run.
- `dir_req`  in  1  0 = forward, 1 = reverse.
- `speed_sel`  in  3  target duty select: 0→0, 1→40, 2→80, 3→120, 4→160, 5→200, 6→240, 7→255.
- `estop`  in  1  emergency stop, level-sensitive.
- `en_a`, `en_b`  out  1 each  PWM-gated H-bridge enables; the two are identical.
- `in1`, `in2`  out  1 each  H-bridge direction pins.
- `duty`  out  8  current ramped duty.
- `state_o`  out  2  IDLE=0, DRIVE=1, STOP=2, DEAD=3.
- `busy`  out  1  1 whenever `state_o` ≠ IDLE.

## Operation
- **Reset values.** All outputs 0, state IDLE, latched direction 0, all counters 0.
- **Direction pins.** Driven only in DRIVE and STOP: latched direction 0 gives in1=1, in2=0; latched direction 1 gives in1=0, in2=1. Both pins are 0 in IDLE and DEAD. They are never both 1.
- **IDLE.** Duty is held at 0. When `run_req`=1 and `estop`=0, latch `dir_req` and go to DRIVE.
- **DRIVE.** Target is the value selected by `speed_sel`.
  - Go to STOP if `run_req`=0, or if `dir_req` ≠ the latched direction.
  - `speed_sel`=0 holds duty 0 but stays in DRIVE with the direction pins driven.
- **STOP.** Target is 0 and `speed_sel` is ignored. When duty reaches 0, go to DEAD and load the dead-time counter.
- **DEAD.** Count `DEADTIME` cycles. At terminal count:
  - if `run_req`=1, latch `dir_req` and go to DRIVE;
  - otherwise go to IDLE.
  - `run_req` toggling during DEAD does not restart the count.
- **estop.** Takes priority over everything in any state.
  - The next edge forces duty=0, the PWM shadow=0 and state=DEAD, with the counter reloaded.
  - The counter holds at reload while `estop`=1.
  - Counting starts on the first cycle after `estop` deasserts.
- **Ramp.**
  - A free-running prescaler counts 0..`RAMP_DIV`-1 and produces a one-cycle tick at terminal count. It is reset only by `rst_n`.
  - On a tick in DRIVE or STOP:
    - if duty < target, duty = min(duty+`RAMP_STEP`, target), computed 9 bits wide;
    - if duty > target, duty = max(duty−`RAMP_STEP`, target), with no underflow.
  - Duty never overshoots its target.
- **PWM.**
  - 8-bit counter `pwm_cnt` runs 0..254 and wraps, giving a period of 255 cycles.
  - A shadow copy of `duty` is loaded when `pwm_cnt`=0 (and by `estop`).
  - `en_a` = `en_b` = (`pwm_cnt` < shadow), registered.
  - Duty 0 gives enables always low; duty 255 gives enables always high.
  - Enables are forced to 0 outside DRIVE and STOP.

## Timing
- `run_req` sampled high in IDLE: state=DRIVE and in1/in2 valid on the next edge. Duty rises starting at the first ramp tick after entry.
- Ramp time from duty a to target b is ceil(|b−a|/`RAMP_STEP`) ticks. With defaults, 0→255 takes 32 ticks.
- A duty change reaches the enables at the next PWM period start, plus one registered cycle.
- STOP→DEAD occurs on the edge after duty=0 is registered. Direction pins fall on that same edge.
- DEAD lasts exactly `DEADTIME` cycles from entry, or from `estop` release. The direction pins for the new direction appear at the exit edge.
- Simultaneous direction change and `run_req` drop in DRIVE: go to STOP, then DEAD, then IDLE.
- `rst_n` low mid-operation: all outputs are 0 immediately (asynchronous), with no stop sequence.

## Test plan
Bench parameters: `RAMP_DIV`=4, `RAMP_STEP`=8, `DEADTIME`=16.
- **Reset.** Assert `rst_n`=0 with any inputs → all outputs 0 and `state_o`=0. Release with `run_req`=0 → outputs remain 0.
- **Ramp up.** `run_req`=1, `dir_req`=0, `speed_sel`=3 → next cycle in1=1, in2=0, `state_o`=1. Duty climbs 8 per 4 cycles and settles at 120 after 15 ticks. Enables are high for 120 of every 255 cycles.
- **Speed change.** At duty 120, set `speed_sel`=1 → duty falls 8 per tick, holds at 40 without undershoot, and state stays DRIVE.
- **Reversal.** At duty 120, set `dir_req`=1 → STOP, ramp to 0, then DEAD with in1=in2=0 for exactly 16 cycles. Then in1=0, in2=1, DRIVE, and duty ramps back to 120.
- **estop.** At duty 200, assert `estop` → next edge duty=0, enables 0, in1=in2=0, `state_o`=3, held for 50 cycles. Release → 16 cycles later state is DRIVE; or IDLE if `run_req` was dropped.
- **Extremes.** `speed_sel`=7 → duty 255 and enables continuously high. Then `speed_sel`=0 → duty 0, enables low, state DRIVE, in1 still 1.
